// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-port VC input buffer, NUM_VCS circular FIFOs sharing one write and one read port.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push/push_vc/indata  write request, target VC, flit
//   pop/pop_vc        read request, VC to dequeue
//   outdata           packed head flit per VC (zero when that VC is empty)
//   empty/full/count  per-VC status derived from occupancy
//   credit_valid/credit_vc  registered credit for each accepted pop
//   overflow_err/underflow_err  sticky dropped-push / ignored-pop flags
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif
module vc_input_buffer #(
    parameter int NUM_VCS = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = `FLIT_DATA_WIDTH,
    localparam int VC_ID_WIDTH = $clog2(NUM_VCS),
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [VC_ID_WIDTH-1:0]          push_vc,
    input  logic [DATA_WIDTH-1:0]           indata,
    input  logic                            pop,
    input  logic [VC_ID_WIDTH-1:0]          pop_vc,
    output logic [NUM_VCS*DATA_WIDTH-1:0]   outdata,
    output logic [NUM_VCS-1:0]              empty,
    output logic [NUM_VCS-1:0]              full,
    output logic [NUM_VCS*CNT_WIDTH-1:0]    count,
    output logic                            credit_valid,
    output logic [VC_ID_WIDTH-1:0]          credit_vc,
    output logic                            overflow_err,
    output logic                            underflow_err
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    logic [DATA_WIDTH-1:0] mem [NUM_VCS][FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr [NUM_VCS];
    logic [PTR_WIDTH-1:0]  rd_ptr [NUM_VCS];
    logic [CNT_WIDTH-1:0]  cnt [NUM_VCS];
    logic                  push_vr, pop_vr, pop_ok, push_ok;
    logic [NUM_VCS-1:0]    push_hit, pop_hit;

    function automatic logic [PTR_WIDTH-1:0] nxt(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A VC id can only fall outside the buffer set when NUM_VCS is not a power of two.
    if (2 ** VC_ID_WIDTH == NUM_VCS) begin : g_pow2
        assign push_vr = 1'b1;
        assign pop_vr  = 1'b1;
    end else begin : g_npow2
        assign push_vr = 32'(push_vc) < NUM_VCS;
        assign pop_vr  = 32'(pop_vc) < NUM_VCS;
    end

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        assign empty[v] = cnt[v] == '0;
        assign full[v]  = cnt[v] == CNT_WIDTH'(FIFO_DEPTH);
        assign count[v*CNT_WIDTH +: CNT_WIDTH] = cnt[v];
        assign outdata[v*DATA_WIDTH +: DATA_WIDTH] = empty[v] ? '0 : mem[v][rd_ptr[v]];
    end

    // A full VC still accepts a push when the same VC is popped this cycle.
    always_comb begin
        pop_ok  = pop && pop_vr && !empty[pop_vc];
        push_ok = push && push_vr && (!full[push_vc] || (pop_ok && pop_vc == push_vc));
        for (int v = 0; v < NUM_VCS; v++) begin
            push_hit[v] = push_ok && push_vc == VC_ID_WIDTH'(v);
            pop_hit[v]  = pop_ok && pop_vc == VC_ID_WIDTH'(v);
        end
    end

    always_ff @(posedge clk)
        if (push_ok)
            mem[push_vc][wr_ptr[push_vc]] <= indata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                cnt[v]    <= '0;
            end
            credit_valid  <= 1'b0;
            credit_vc     <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (push_hit[v])
                    wr_ptr[v] <= nxt(wr_ptr[v]);
                if (pop_hit[v])
                    rd_ptr[v] <= nxt(rd_ptr[v]);
                cnt[v] <= cnt[v] + CNT_WIDTH'(push_hit[v]) - CNT_WIDTH'(pop_hit[v]);
            end
            credit_valid <= pop_ok;
            if (pop_ok)
                credit_vc <= pop_vc;
            if (push && !push_ok)
                overflow_err <= 1'b1;
            if (pop && !pop_ok)
                underflow_err <= 1'b1;
        end
    end
endmodule
